// File: rtl/regfile_dump.sv
// regfile_dump: parametrised register file with bypass and a handshaked sequential dump engine
module regfile_dump #(
  parameter int WIDTH = 32,
  parameter int ADDR_W = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [WIDTH-1:0]  WD3,
  output logic [WIDTH-1:0]  RD1,
  output logic [WIDTH-1:0]  RD2,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_index,
  output logic [WIDTH-1:0]  dump_data,
  output logic              dump_done
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic wr_ok;
  always_comb begin
    wr_ok = write_enable && !(ZERO_REG != 0 && A3 == '0);
    RD1 = BYPASS != 0 && wr_ok && A3 == A1 ? WD3 : ZERO_REG != 0 && A1 == '0 ? '0 : mem[A1];
    RD2 = BYPASS != 0 && wr_ok && A3 == A2 ? WD3 : ZERO_REG != 0 && A2 == '0 ? '0 : mem[A2];
  end
  always_ff @(posedge clk)
    if (reset) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (wr_ok) mem[A3] <= WD3;
  // LOAD samples the stored array, so a same-edge write to that index is not captured
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      dump_busy <= 1'b0;
      dump_valid <= 1'b0;
      dump_done <= 1'b0;
      dump_index <= '0;
      dump_data <= '0;
    end else
      case (state)
        IDLE: if (dump_start) begin
          state <= LOAD;
          dump_busy <= 1'b1;
          dump_index <= '0;
        end
        LOAD: begin
          dump_data <= ZERO_REG != 0 && dump_index == '0 ? '0 : mem[dump_index];
          dump_valid <= 1'b1;
          state <= SEND;
        end
        SEND: if (dump_ready) begin
          dump_valid <= 1'b0;
          if (&dump_index) begin
            state <= DONE;
            dump_done <= 1'b1;
          end else begin
            dump_index <= dump_index + 1'b1;
            state <= LOAD;
          end
        end
        default: begin
          dump_done <= 1'b0;
          dump_busy <= 1'b0;
          state <= IDLE;
        end
      endcase
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: scoreboard bench for regfile_dump (default instance plus ZERO_REG=0/BYPASS=0 instance)
module tb_regfile_dump;
  logic clk = 0, reset = 1, write_enable = 0, dump_start = 0, dump_ready = 0;
  logic [4:0] A1 = 0, A2 = 0, A3 = 0;
  logic [31:0] WD3 = 0;
  logic [31:0] RD1, RD2, dump_data, u1_rd1, u1_rd2, u1_data;
  logic dump_busy, dump_valid, dump_done, u1_busy, u1_valid, u1_done;
  logic [4:0] dump_index, u1_index;
  int checks = 0, errors = 0, done_cnt = 0;
  typedef struct {logic [4:0] idx; logic [31:0] data;} exp_t;
  exp_t exp_q[$];
  exp_t cur;

  regfile_dump u0 (.clk(clk), .reset(reset), .write_enable(write_enable), .A1(A1), .A2(A2), .A3(A3),
    .WD3(WD3), .RD1(RD1), .RD2(RD2), .dump_start(dump_start), .dump_busy(dump_busy),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_index(dump_index),
    .dump_data(dump_data), .dump_done(dump_done));
  regfile_dump #(.ZERO_REG(0), .BYPASS(0)) u1 (.clk(clk), .reset(reset), .write_enable(write_enable),
    .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .RD1(u1_rd1), .RD2(u1_rd2), .dump_start(1'b0),
    .dump_busy(u1_busy), .dump_valid(u1_valid), .dump_ready(1'b0), .dump_index(u1_index),
    .dump_data(u1_data), .dump_done(u1_done));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump(input int kind);
    for (int i = 0; i < 32; i++) begin
      cur.idx = 5'(i);
      cur.data = kind == 0 ? 32'(i * 'h11) : kind == 1 ? (i == 3 ? 32'hFFFF : 32'(i * 'h11)) : 32'h0;
      exp_q.push_back(cur);
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!dump_done && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_timeout"}, 32'(dump_done), 32'h1);
    tick();
  endtask

  always @(negedge clk) begin
    if (!reset && dump_valid && dump_ready) begin
      if (exp_q.size() == 0) chk("dump_unexpected_beat", 32'h1, 32'h0);
      else begin
        cur = exp_q.pop_front();
        chk("dump_index", 32'(dump_index), 32'(cur.idx));
        chk("dump_data", dump_data, cur.data);
      end
    end
    if (!reset && dump_done) done_cnt++;
  end

  initial begin
    int first_v, done_at;
    bit found;
    tick();
    tick();
    reset = 0;
    A1 = 5;
    A2 = 31;
    @(negedge clk);
    chk("rst_busy", 32'(dump_busy), 0);
    chk("rst_valid", 32'(dump_valid), 0);
    chk("rst_done", 32'(dump_done), 0);
    chk("rst_index", 32'(dump_index), 0);
    chk("rst_data", dump_data, 0);
    chk("rst_rd1", RD1, 0);
    chk("rst_rd2", RD2, 0);
    tick();
    write_enable = 1; A3 = 5; WD3 = 32'hDEADBEEF;
    tick();
    write_enable = 0; A1 = 5; A2 = 7;
    @(negedge clk);
    chk("rd1_reg5", RD1, 32'hDEADBEEF);
    chk("rd2_reg7", RD2, 0);
    chk("u1_rd1_reg5", u1_rd1, 32'hDEADBEEF);
    tick();
    write_enable = 1; A3 = 0; WD3 = 32'h1234; A1 = 0;
    @(negedge clk);
    chk("zero_bypass_suppressed", RD1, 0);
    chk("u1_zero_nobypass", u1_rd1, 0);
    tick();
    write_enable = 0;
    @(negedge clk);
    chk("zero_reg_read", RD1, 0);
    chk("u1_reg0_written", u1_rd1, 32'h1234);
    tick();
    write_enable = 1; A3 = 9; A1 = 9; A2 = 9; WD3 = 32'hA5A5A5A5;
    @(negedge clk);
    chk("bypass_rd1", RD1, 32'hA5A5A5A5);
    chk("bypass_rd2", RD2, 32'hA5A5A5A5);
    chk("u1_nobypass_rd1", u1_rd1, 0);
    chk("u1_nobypass_rd2", u1_rd2, 0);
    tick();
    write_enable = 0;
    @(negedge clk);
    chk("u1_after_write", u1_rd1, 32'hA5A5A5A5);
    tick();
    for (int i = 0; i < 32; i++) begin
      write_enable = 1; A3 = 5'(i); WD3 = 32'(i * 'h11);
      tick();
    end
    write_enable = 0;
    push_dump(0);
    dump_ready = 1; dump_start = 1;
    first_v = -1; done_at = -1;
    for (int n = 1; n <= 200 && done_at < 0; n++) begin
      tick();
      if (n == 1) begin
        dump_start = 0;
        chk("busy_after_start", 32'(dump_busy), 1);
      end
      if (dump_valid && first_v < 0) first_v = n;
      if (dump_done) done_at = n;
    end
    chk("first_valid_latency", 32'(first_v), 2);
    chk("done_latency", 32'(done_at), 65);
    chk("busy_in_done", 32'(dump_busy), 1);
    dump_start = 1;
    tick();
    chk("busy_after_done", 32'(dump_busy), 0);
    dump_start = 0;
    repeat (3) tick();
    chk("start_in_done_ignored", 32'(dump_busy), 0);
    chk("done_once", 32'(done_cnt), 1);
    chk("queue_drained1", 32'(exp_q.size()), 0);
    push_dump(0);
    dump_start = 1;
    found = 0;
    for (int n = 0; n < 100 && !found; n++) begin
      tick();
      dump_start = 0;
      found = dump_busy && !dump_valid && dump_index == 3;
    end
    chk("reach_load3", 32'(found), 1);
    dump_ready = 0; write_enable = 1; A3 = 3; WD3 = 32'hFFFF;
    tick();
    write_enable = 0; A1 = 3;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(dump_valid), 1);
      chk("hold_index", 32'(dump_index), 3);
      chk("hold_data", dump_data, 32'h33);
      tick();
    end
    chk("reg3_written", RD1, 32'hFFFF);
    dump_ready = 1;
    tick();
    chk("advance_index4", 32'(dump_index), 4);
    wait_done("hold_dump");
    chk("done_twice", 32'(done_cnt), 2);
    chk("queue_drained2", 32'(exp_q.size()), 0);
    push_dump(1);
    dump_start = 1;
    found = 0;
    for (int n = 0; n < 100 && !found; n++) begin
      tick();
      dump_start = 0;
      found = dump_valid && dump_index == 10;
    end
    chk("reach_send10", 32'(found), 1);
    reset = 1;
    tick();
    reset = 0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_busy", 32'(dump_busy), 0);
    chk("abort_valid", 32'(dump_valid), 0);
    chk("abort_done", 32'(dump_done), 0);
    chk("abort_index", 32'(dump_index), 0);
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i); A2 = 5'(31 - i);
      #0.1;
      chk("cleared_rd1", RD1, 0);
      chk("cleared_u1_rd2", u1_rd2, 0);
    end
    tick();
    push_dump(2);
    dump_start = 1;
    tick();
    dump_start = 0;
    wait_done("redump");
    chk("done_after_abort", 32'(done_cnt), 3);
    chk("queue_drained3", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Parametrised successor to the 32x32 CPU register file: configurable width and depth, optional hardwired-zero entry 0, optional write-to-read bypass.
- Adds a sequential dump engine that streams every register, in index order, over a valid/ready handshake. It feeds the UART debug path and replaces the single combinational debug mux.
- Sits in the single-cycle core between decode and ALU; the dump port connects to the UART transmit framer.

Parameters:
- WIDTH, 32, data width of each register.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1, 1 = entry 0 reads as zero and ignores writes; 0 = entry 0 is an ordinary register.
- BYPASS, 1, 1 = a read of the register being written this cycle returns WD3; 0 = it returns the stored value.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- write_enable  in  1  write strobe for port 3.
- A1  in  ADDR_W  read address, port 1.
- A2  in  ADDR_W  read address, port 2.
- A3  in  ADDR_W  write address.
- WD3  in  WIDTH  write data.
- RD1  out  WIDTH  combinational read data, port 1.
- RD2  out  WIDTH  combinational read data, port 2.
- dump_start  in  1  request a full dump; sampled only in IDLE.
- dump_busy  out  1  high from the cycle after an accepted start until the DONE cycle, inclusive.
- dump_valid  out  1  dump_data and dump_index are valid.
- dump_ready  in  1  consumer accepts the current word.
- dump_index  out  ADDR_W  index of the word being presented.
- dump_data  out  WIDTH  register contents captured for dump_index.
- dump_done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (synchronous): all registers become 0; FSM goes to IDLE; dump_busy, dump_valid and dump_done are 0; dump_index and dump_data are 0. Reset during a dump aborts it; no dump_done pulse is issued.
- Write: on a clock edge with write_enable=1, reg[A3] <= WD3. When ZERO_REG=1 and A3=0, the write is dropped.
- Read: RD1 = reg[A1] and RD2 = reg[A2], combinationally. When ZERO_REG=1, address 0 returns 0.
- Bypass: when BYPASS=1, write_enable=1 and A3==A1, RD1 = WD3 in the same cycle; RD2 likewise for A2. Bypass is suppressed for A3=0 when ZERO_REG=1.
- Dump FSM states: IDLE, LOAD, SEND, DONE.
  - IDLE: dump_start=1 -> LOAD with index=0.
  - LOAD: dump_data <= value of reg[index] as read through the read path (ZERO_REG applies, BYPASS does not); -> SEND.
  - SEND: dump_valid=1. dump_data and dump_index hold stable while dump_ready=0, even if that register is written meanwhile. On dump_valid & dump_ready: if index==DEPTH-1 -> DONE, else index+1 -> LOAD.
  - DONE: dump_done=1 for exactly one cycle; -> IDLE; dump_busy drops on the following cycle.
- Throughput: at most one word every 2 cycles. Start to first dump_valid is 2 cycles. A full dump with ready tied high takes 2*DEPTH+1 cycles from the start edge to the dump_done pulse.
- dump_start is ignored while not in IDLE. A start asserted in the DONE cycle is ignored; it must be re-asserted in IDLE.
- Index wrap: index never increments past DEPTH-1; completion goes through DONE.
- Normal reads and writes are never stalled by a dump. A write landing in the LOAD cycle for the same index is not captured; the pre-write value is dumped.

Test Plan:
- Reset, then write reg5=0xDEADBEEF; next cycle A1=5 -> RD1=0xDEADBEEF; A2=7 -> RD2=0.
- ZERO_REG=1: write A3=0, WD3=0x1234 -> RD1 at A1=0 is 0. ZERO_REG=0 same stimulus -> RD1=0x1234 on the next cycle.
- BYPASS=1: A1=A3=9, write_enable=1, WD3=0xA5A5A5A5 -> RD1=0xA5A5A5A5 in the same cycle. BYPASS=0 -> RD1 shows the old value (0) in that cycle.
- Preload reg[i]=i*0x11; dump_start with dump_ready=1 -> DEPTH beats, index 0..31 with data i*0x11. dump_done pulses exactly once, 65 cycles after start.
- During a dump, hold dump_ready=0 for 5 cycles at index 3 while writing reg3=0xFFFF -> dump_data stays 3*0x11. Release ready -> index advances to 4.
- Assert reset at index 10 mid-dump -> next cycle dump_busy, dump_valid and dump_done are 0, all registers read 0. A new dump_start dumps again from index 0.
